alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Flow per operation: grant in IDLE, one EXEC cycle, then RESP until the
// response is taken. Arbitration is round-robin by default. Define
// ALU_ARB_FIXED_PRI_EN to make it fixed priority, with requester 0 winning.
// An op whose sel[5] is set is answered with an error and never reaches the ALU.
module alu_arbiter #(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [5:0]        req0_sel,
  input  logic              req0_cin,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [5:0]        req1_sel,
  input  logic              req1_cin,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [5:0]        alu_sel,
  output logic              alu_cin,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_err
);

  localparam int unsigned SEL_W   = 6;
  localparam int unsigned DIS_BIT = 5;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              grant0_c, grant1_c, accept_c;
  logic [SEL_W-1:0]  gnt_sel_c;
  logic              gnt_cin_c;
  logic [DATA_W-1:0] gnt_a_c, gnt_b_c;

  logic              rsp_valid_d, rsp_id_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_y_d;
  logic [SEL_W-1:0]  alu_sel_d;
  logic              alu_cin_d;
  logic [DATA_W-1:0] alu_a_d, alu_b_d;

`ifndef ALU_ARB_FIXED_PRI_EN
  logic last_q, last_d;
`endif

  // Pick the winner among the valid requesters.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRI_EN
    grant0_c = req0_valid;
`else
    grant0_c = req0_valid & (~req1_valid | last_q);
`endif
    grant1_c = req1_valid & ~grant0_c;
  end

  assign accept_c   = (state_q == IDLE) & (req0_valid | req1_valid);
  assign req0_ready = rst_n & (state_q == IDLE) & grant0_c;
  assign req1_ready = rst_n & (state_q == IDLE) & grant1_c;

  assign gnt_sel_c = grant1_c ? req1_sel : req0_sel;
  assign gnt_cin_c = grant1_c ? req1_cin : req0_cin;
  assign gnt_a_c   = grant1_c ? req1_a   : req0_a;
  assign gnt_b_c   = grant1_c ? req1_b   : req0_b;

  // Next-state and next-register values for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid;
    rsp_id_d    = rsp_id;
    rsp_err_d   = rsp_err;
    rsp_y_d     = rsp_y;
    alu_sel_d   = alu_sel;
    alu_cin_d   = alu_cin;
    alu_a_d     = alu_a;
    alu_b_d     = alu_b;
`ifndef ALU_ARB_FIXED_PRI_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d   = EXEC;
          rsp_id_d  = grant1_c;
          rsp_err_d = gnt_sel_c[DIS_BIT];
`ifndef ALU_ARB_FIXED_PRI_EN
          last_d    = grant1_c;
`endif
          // A disabled op leaves the ALU drive untouched.
          if (!gnt_sel_c[DIS_BIT]) begin
            alu_sel_d = gnt_sel_c;
            alu_cin_d = gnt_cin_c;
            alu_a_d   = gnt_a_c;
            alu_b_d   = gnt_b_c;
          end
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_y_d     = rsp_err ? '0 : alu_y;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_y     <= '0;
      alu_sel   <= '0;
      alu_cin   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
`ifndef ALU_ARB_FIXED_PRI_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_err   <= rsp_err_d;
      rsp_y     <= rsp_y_d;
      alu_sel   <= alu_sel_d;
      alu_cin   <= alu_cin_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
`ifndef ALU_ARB_FIXED_PRI_EN
      last_q    <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus a randomized run against
// a transaction-level reference model. Also provides a model of the shared ALU.
module tb_alu_arbiter;

  localparam int unsigned DW = 12;

  logic          clk, rst_n;
  logic          req0_valid, req0_ready, req0_cin;
  logic [5:0]    req0_sel;
  logic [DW-1:0] req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_cin;
  logic [5:0]    req1_sel;
  logic [DW-1:0] req1_a, req1_b;
  logic [5:0]    alu_sel;
  logic          alu_cin;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DW-1:0] rsp_y;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_cin(req0_cin), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_cin(req1_cin), .req1_a(req1_a), .req1_b(req1_b),
    .alu_sel(alu_sel), .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: bits4:3 shift b left, bit2 picks logic/arith, bits1:0 the op.
  function automatic logic [DW-1:0] alu_fn(input logic [5:0] s, input logic c,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] bs;
    bs = b << s[4:3];
    if (s[2]) begin
      case (s[1:0])
        2'd0:    alu_fn = a | bs;
        2'd1:    alu_fn = a ^ bs;
        2'd2:    alu_fn = a & bs;
        default: alu_fn = ~a;
      endcase
    end else begin
      case (s[1:0])
        2'd0:    alu_fn = a;
        2'd1:    alu_fn = a + DW'(c);
        2'd2:    alu_fn = a + bs + DW'(c);
        default: alu_fn = a + ~bs + DW'(c);
      endcase
    end
  endfunction

  assign alu_y = alu_fn(alu_sel, alu_cin, alu_a, alu_b);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [5:0] s,
                         input logic c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (id == 0) begin
      req0_valid = v; req0_sel = s; req0_cin = c; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_sel = s; req1_cin = c; req1_a = a; req1_b = b;
    end
  endtask

  task automatic reset_dut;
    set_req(0, 1'b0, '0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0, '0);
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 6'b000010, 1'b1, 12'h111, 12'h222);
    set_req(1, 1'b1, 6'b000010, 1'b1, 12'h333, 12'h444);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err} !== 5'b0) begin
        errors++; $display("FAIL reset_ctrl: got %b exp 00000", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err});
      end
      checks++;
      if ({rsp_y, alu_a, alu_b, alu_sel, alu_cin} !== '0) begin
        errors++; $display("FAIL reset_data: rsp_y=%h alu_a=%h alu_b=%h alu_sel=%b alu_cin=%b exp all 0",
                           rsp_y, alu_a, alu_b, alu_sel, alu_cin);
      end
      tick;
    end
  endtask

  task automatic test_basic;
    reset_dut;
    set_req(0, 1'b1, 6'b000010, 1'b0, 12'd5, 12'd3);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL basic_ready: got %b exp 10", {req0_ready, req1_ready});
    end
    tick;
    req0_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL basic_exec_valid: got %b exp 0", rsp_valid);
    end
    checks++;
    if ({alu_sel, alu_cin, alu_a, alu_b} !== {6'b000010, 1'b0, 12'd5, 12'd3}) begin
      errors++; $display("FAIL basic_alu_drive: got sel=%b cin=%b a=%0d b=%0d exp 000010/0/5/3", alu_sel, alu_cin, alu_a, alu_b);
    end
    tick;
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_y} !== {1'b1, 1'b0, 1'b0, 12'd8}) begin
      errors++; $display("FAIL basic_rsp: got v=%b id=%b err=%b y=%0d exp 1/0/0/8", rsp_valid, rsp_id, rsp_err, rsp_y);
    end
    tick;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL basic_rsp_drop: got %b exp 0", rsp_valid);
    end
  endtask

  task automatic test_alternate;
    logic          ids [4];
    logic [DW-1:0] ys  [4];
    int            n;
    logic          exp_id;
    reset_dut;
    set_req(0, 1'b1, 6'b000001, 1'b1, 12'd1, 12'd0);
    set_req(1, 1'b1, 6'b000101, 1'b1, 12'd7, 12'd2);
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      tick;
      if (rsp_valid) begin
        ids[n] = rsp_id;
        ys[n]  = rsp_y;
        n++;
      end
    end
    set_req(0, 1'b0, '0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0, '0);
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL alt_timeout: got %0d responses exp 4", n);
    end
    for (int k = 0; k < n; k++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      exp_id = 1'b0;
`else
      exp_id = k[0];
`endif
      checks++;
      if (ids[k] !== exp_id || ys[k] !== (exp_id ? 12'd5 : 12'd2)) begin
        errors++; $display("FAIL alt_rsp%0d: got id=%b y=%0d exp id=%b y=%0d", k, ids[k], ys[k], exp_id, exp_id ? 5 : 2);
      end
    end
  endtask

  task automatic test_back_pressure;
    reset_dut;
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 6'b000010, 1'b1, 12'd10, 12'd20);
    tick;
    set_req(0, 1'b0, '0, 1'b0, '0, '0);
    set_req(1, 1'b1, 6'b000000, 1'b0, 12'h0AA, 12'h000);
    tick;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_y, req0_ready, req1_ready} !== {1'b1, 1'b0, 12'd31, 2'b00}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b id=%b y=%0d rdy=%b%b exp 1/0/31/00",
                           k, rsp_valid, rsp_id, rsp_y, req0_ready, req1_ready);
      end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
      errors++; $display("FAIL bp_release: got v=%b rdy=%b%b exp 0/01", rsp_valid, req0_ready, req1_ready);
    end
    tick;
    req1_valid = 1'b0;
    tick;
    checks++;
    if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b1, 12'h0AA}) begin
      errors++; $display("FAIL bp_pending: got v=%b id=%b y=%h exp 1/1/0aa", rsp_valid, rsp_id, rsp_y);
    end
  endtask

  task automatic test_err;
    reset_dut;
    set_req(0, 1'b1, 6'b000010, 1'b0, 12'h123, 12'h011);
    tick;
    req0_valid = 1'b0;
    tick;
    tick;
    set_req(1, 1'b1, 6'b100000, 1'b1, 12'hABC, 12'h555);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL err_ready: got %b exp 01", {req0_ready, req1_ready});
    end
    tick;
    req1_valid = 1'b0;
    checks++;
    if ({alu_sel, alu_cin, alu_a, alu_b} !== {6'b000010, 1'b0, 12'h123, 12'h011}) begin
      errors++; $display("FAIL err_alu_hold: got sel=%b cin=%b a=%h b=%h exp 000010/0/123/011", alu_sel, alu_cin, alu_a, alu_b);
    end
    tick;
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_y} !== {1'b1, 1'b1, 1'b1, 12'h000}) begin
      errors++; $display("FAIL err_rsp: got v=%b id=%b err=%b y=%h exp 1/1/1/000", rsp_valid, rsp_id, rsp_err, rsp_y);
    end
    tick;
  endtask

  task automatic test_reset_in_exec;
    reset_dut;
    set_req(0, 1'b1, 6'b000010, 1'b0, 12'd5, 12'd3);
    tick;
    set_req(0, 1'b1, 6'b000001, 1'b1, 12'h0FF, 12'h000);
    set_req(1, 1'b1, 6'b000101, 1'b0, 12'h00F, 12'h001);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_y, alu_sel, alu_cin, alu_a, alu_b} !== '0) begin
      errors++; $display("FAIL rst_exec_clear: rdy=%b%b v=%b y=%h alu_a=%h alu_sel=%b exp all 0",
                         req0_ready, req1_ready, rsp_valid, rsp_y, alu_a, alu_sel);
    end
    tick;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL rst_exec_first: got rdy=%b%b v=%b exp 10/0", req0_ready, req1_ready, rsp_valid);
    end
    tick;
    set_req(0, 1'b0, '0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0, '0);
    tick;
    checks++;
    if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 12'h100}) begin
      errors++; $display("FAIL rst_exec_next: got v=%b id=%b y=%h exp 1/0/100", rsp_valid, rsp_id, rsp_y);
    end
    tick;
  endtask

  task automatic test_passthru;
    reset_dut;
    set_req(0, 1'b1, 6'b001100, 1'b0, 12'h800, 12'h000);
    tick;
    req0_valid = 1'b0;
    tick;
    checks++;
    if ({rsp_valid, rsp_err, rsp_y} !== {1'b1, 1'b0, 12'h800}) begin
      errors++; $display("FAIL passthru: got v=%b err=%b y=%h exp 1/0/800", rsp_valid, rsp_err, rsp_y);
    end
    tick;
  endtask

  // Random traffic against a transaction-level model: one op in flight,
  // response visible from the second edge after acceptance.
  task automatic test_random(input int n);
    logic          v [2];
    logic [5:0]    ps [2];
    logic          pc [2];
    logic [DW-1:0] pa [2], pb [2];
    logic          busy, last, ex_id, ex_err, w0, w1, g0, g1, exp_rv, hs;
    int            age;
    logic [DW-1:0] ex_y, ex_a, ex_b;
    logic [5:0]    ex_sel;
    logic          ex_cin;
    reset_dut;
    busy = 1'b0; last = 1'b1; age = 0;
    ex_id = 1'b0; ex_err = 1'b0; ex_y = '0;
    ex_sel = '0; ex_cin = 1'b0; ex_a = '0; ex_b = '0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; ps[i] = '0; pc[i] = 1'b0; pa[i] = '0; pb[i] = '0;
    end
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i]  = 1'b1;
          ps[i] = 6'($urandom);
          ps[i][5] = ($urandom_range(0, 7) == 0);
          pc[i] = 1'($urandom);
          pa[i] = DW'($urandom);
          pb[i] = DW'($urandom);
        end
        set_req(i, v[i], ps[i], pc[i], pa[i], pb[i]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
`ifdef ALU_ARB_FIXED_PRI_EN
      w0 = v[0];
`else
      w0 = v[0] && (!v[1] || last);
`endif
      w1 = v[1] && !w0;
      g0 = !busy && w0;
      g1 = !busy && w1;
      exp_rv = busy && (age >= 2);
      checks++;
      if ({req0_ready, req1_ready} !== {g0, g1}) begin
        errors++; $display("FAIL rnd_ready c%0d: got %b%b exp %b%b", cyc, req0_ready, req1_ready, g0, g1);
      end
      checks++;
      if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_err, rsp_y} !== {ex_id, ex_err, ex_y})) begin
        errors++; $display("FAIL rnd_rsp c%0d: got v=%b id=%b err=%b y=%h exp v=%b id=%b err=%b y=%h",
                           cyc, rsp_valid, rsp_id, rsp_err, rsp_y, exp_rv, ex_id, ex_err, ex_y);
      end
      checks++;
      if ({alu_sel, alu_cin, alu_a, alu_b} !== {ex_sel, ex_cin, ex_a, ex_b}) begin
        errors++; $display("FAIL rnd_alu c%0d: got sel=%b cin=%b a=%h b=%h exp sel=%b cin=%b a=%h b=%h",
                           cyc, alu_sel, alu_cin, alu_a, alu_b, ex_sel, ex_cin, ex_a, ex_b);
      end
      hs = exp_rv && rsp_ready;
      tick;
      if (hs) busy = 1'b0;
      else if (busy) age++;
      if (g0 || g1) begin
        ex_id  = g1;
        ex_err = ps[ex_id][5];
        ex_y   = ex_err ? '0 : alu_fn(ps[ex_id], pc[ex_id], pa[ex_id], pb[ex_id]);
        if (!ex_err) begin
          ex_sel = ps[ex_id]; ex_cin = pc[ex_id]; ex_a = pa[ex_id]; ex_b = pb[ex_id];
        end
        last  = ex_id;
        v[ex_id] = 1'b0;
        busy = 1'b1;
        age  = 1;
      end
    end
    set_req(0, 1'b0, '0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, '0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0, '0);
    test_reset;
    test_basic;
    test_alternate;
    test_back_pressure;
    test_err;
    test_reset_in_exec;
    test_passthru;
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
